lsu_mem_stage: RTL and testbench

- Memory-access stage that consumes the execute stage's result (valE as effective address, rs2 as store data) and performs the load or store on the data-memory bus.
- Uses a req/ack handshake on that bus.
- Aligns and sign/zero-extends load data, generates byte strobes for stores, and reports completion, misalignment and bus errors to the sequencer.
- Sits between execute and writeback in the sequential core.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_stage.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, state encoding and small helpers for the load/store memory stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // size encodes 1/2/4/8 bytes as 0/1/2/3
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] strb;
    case (size)
      2'b00:   strb = 8'h01 << off;
      2'b01:   strb = 8'h03 << off;
      2'b10:   strb = 8'h0F << off;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: picks the addressed lane and sign/zero-extends it.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] load_data
);

  logic [63:0] lane_s;

  // shift the addressed byte lane down to bit 0, then extend per funct3
  always_comb begin
    lane_s    = rdata >> {off, 3'b000};
    load_data = 64'h0;
    case (funct3)
      F3_B:    load_data = {{56{lane_s[7]}},  lane_s[7:0]};
      F3_H:    load_data = {{48{lane_s[15]}}, lane_s[15:0]};
      F3_W:    load_data = {{32{lane_s[31]}}, lane_s[31:0]};
      F3_D:    load_data = lane_s;
      F3_BU:   load_data = {56'h0, lane_s[7:0]};
      F3_HU:   load_data = {48'h0, lane_s[15:0]};
      F3_WU:   load_data = {32'h0, lane_s[31:0]};
      default: load_data = 64'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: runs one load or store per accepted start over a req/ack data bus,
// reporting completion, misalignment and bus errors back to the sequencer.
module lsu_mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] valE,
  input  logic [63:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [63:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_e      state_r;
  logic [7:0]  wait_cnt_r;
  logic [2:0]  off_r;
  logic [2:0]  f3_r;
  logic        is_store_r;

  logic        illegal_s;
  logic        misaligned_s;
  logic [63:0] shifted_wdata_s;
  logic [7:0]  strb_s;
  logic [63:0] align_data_s;

  // decode the incoming request before it is latched
  always_comb begin
    illegal_s       = 1'b0;
    misaligned_s    = 1'b0;
    shifted_wdata_s = store_data << {valE[2:0], 3'b000};
    strb_s          = store_strb(funct3[1:0], valE[2:0]);
    if ((mem_read && mem_write) || (mem_write && funct3[2]) ||
        (mem_read && (funct3 == F3_ILL))) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
    misaligned_s = is_misaligned(funct3[1:0], valE[2:0]);
  end

  lsu_load_align u_align (
    .rdata     (dmem_rdata),
    .off       (off_r),
    .funct3    (f3_r),
    .load_data (align_data_s)
  );

  // transaction sequencer; every output is driven from here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
      off_r      <= 3'd0;
      f3_r       <= 3'd0;
      is_store_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= 64'h0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'h0;
      dmem_wdata <= 64'h0;
      dmem_wstrb <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            off_r      <= valE[2:0];
            f3_r       <= funct3;
            is_store_r <= mem_write;
            wait_cnt_r <= 8'd0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            load_data  <= 64'h0;
            busy       <= 1'b1;
            if (!mem_read && !mem_write) begin
              state_r <= RESP;
              done    <= 1'b1;
            end else if (illegal_s) begin
              bus_err <= 1'b1;
              state_r <= RESP;
              done    <= 1'b1;
            end else if (misaligned_s) begin
              misalign <= 1'b1;
              state_r  <= RESP;
              done     <= 1'b1;
            end else begin
              state_r    <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {valE[63:3], 3'b000};
              dmem_wdata <= mem_write ? shifted_wdata_s : 64'h0;
              dmem_wstrb <= mem_write ? strb_s : 8'h00;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            load_data  <= is_store_r ? 64'h0 : align_data_s;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 8'h00;
            done       <= 1'b1;
            state_r    <= RESP;
          end else if (wait_cnt_r == LIMIT_M1) begin
            load_data  <= 64'h0;
            bus_err    <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 8'h00;
            done       <= 1'b1;
            state_r    <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        RESP: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          dmem_wstrb <= 8'h00;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, loads, error paths, timeout and mid-transaction reset.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] valE = 64'h0;
  logic [63:0] store_data = 64'h0;
  logic        busy, done, misalign, bus_err, dmem_req, dmem_we;
  logic [63:0] load_data, dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = 64'h0;

  int total = 0;
  int bad = 0;

  lsu_mem_stage #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .valE(valE), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] data);
    start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; valE = addr; store_data = data;
    step();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++; if ({busy, done, dmem_req, misalign, bus_err} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", {busy, done, dmem_req, misalign, bus_err}, 5'b0); end
    total++; if (load_data !== 64'h0 || dmem_wstrb !== 8'h00) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", load_data, dmem_wstrb); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sd();
    do_start(1'b0, 1'b1, 3'b011, 64'h100, 64'h1122334455667788);
    total++; if ({dmem_req, dmem_we, busy} !== 3'b111) begin bad++; $display("FAIL sd_req got=%b exp=111", {dmem_req, dmem_we, busy}); end
    total++; if (dmem_addr !== 64'h100) begin bad++; $display("FAIL sd_addr got=%h exp=%h", dmem_addr, 64'h100); end
    total++; if (dmem_wstrb !== 8'hFF) begin bad++; $display("FAIL sd_wstrb got=%h exp=ff", dmem_wstrb); end
    total++; if (dmem_wdata !== 64'h1122334455667788) begin bad++; $display("FAIL sd_wdata got=%h exp=1122334455667788", dmem_wdata); end
    step(); step();
    total++; if (dmem_req !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL sd_hold got=%b%b exp=10", dmem_req, done); end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    total++; if ({done, dmem_req, misalign, bus_err} !== 4'b1000) begin bad++; $display("FAIL sd_done got=%b exp=1000", {done, dmem_req, misalign, bus_err}); end
    step();
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL sd_idle got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_sb_sh();
    do_start(1'b0, 1'b1, 3'b000, 64'h103, 64'hAB);
    total++; if (dmem_wstrb !== 8'h08 || dmem_wdata !== 64'h00000000AB000000) begin bad++; $display("FAIL sb_lane got=%h/%h exp=08/00000000ab000000", dmem_wstrb, dmem_wdata); end
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || dmem_wstrb !== 8'h00) begin bad++; $display("FAIL sb_done got=%b/%h exp=1/00", done, dmem_wstrb); end
    step();
    do_start(1'b0, 1'b1, 3'b001, 64'h106, 64'h1234);
    total++; if (dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'h1234000000000000) begin bad++; $display("FAIL sh_lane got=%h/%h exp=c0/1234000000000000", dmem_wstrb, dmem_wdata); end
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    step();
  endtask

  task automatic test_loads();
    do_start(1'b1, 1'b0, 3'b000, 64'h105, 64'h0);
    total++; if ({dmem_req, dmem_we} !== 2'b10 || dmem_wstrb !== 8'h00 || dmem_addr !== 64'h100) begin bad++; $display("FAIL lb_req got=%b/%h/%h exp=10/00/100", {dmem_req, dmem_we}, dmem_wstrb, dmem_addr); end
    dmem_rdata = 64'h0000800000000000; dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || load_data !== 64'hFFFFFFFFFFFFFF80) begin bad++; $display("FAIL lb_data got=%b/%h exp=1/ffffffffffffff80", done, load_data); end
    step();
    do_start(1'b1, 1'b0, 3'b100, 64'h105, 64'h0);
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    total++; if (load_data !== 64'h80) begin bad++; $display("FAIL lbu_data got=%h exp=80", load_data); end
    step();
    do_start(1'b1, 1'b0, 3'b010, 64'h104, 64'h0);
    dmem_rdata = 64'h7FFF0000_12345678; step(); step();
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    total++; if (load_data !== 64'h000000007FFF0000) begin bad++; $display("FAIL lw_data got=%h exp=000000007fff0000", load_data); end
    step();
    do_start(1'b1, 1'b0, 3'b001, 64'h102, 64'h0);
    dmem_rdata = 64'h0000000080010000; dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    step(); step();
    total++; if (load_data !== 64'hFFFFFFFFFFFF8001 || busy !== 1'b0) begin bad++; $display("FAIL lh_hold got=%h/%b exp=ffffffffffff8001/0", load_data, busy); end
  endtask

  task automatic test_errors();
    do_start(1'b1, 1'b0, 3'b010, 64'h102, 64'h0);
    total++; if ({done, misalign, bus_err, dmem_req} !== 4'b1100 || load_data !== 64'h0) begin bad++; $display("FAIL misalign got=%b/%h exp=1100/0", {done, misalign, bus_err, dmem_req}, load_data); end
    step();
    total++; if ({done, misalign, dmem_req} !== 3'b010) begin bad++; $display("FAIL misalign_hold got=%b exp=010", {done, misalign, dmem_req}); end
    do_start(1'b1, 1'b1, 3'b011, 64'h100, 64'h0);
    total++; if ({done, misalign, bus_err, dmem_req} !== 4'b1010) begin bad++; $display("FAIL rdwr_err got=%b exp=1010", {done, misalign, bus_err, dmem_req}); end
    step();
    do_start(1'b0, 1'b1, 3'b100, 64'h100, 64'h0);
    total++; if ({done, bus_err, dmem_req} !== 3'b110) begin bad++; $display("FAIL st_f3_err got=%b exp=110", {done, bus_err, dmem_req}); end
    step();
    do_start(1'b0, 1'b0, 3'b011, 64'h100, 64'h0);
    total++; if ({done, bus_err, misalign, dmem_req} !== 4'b1000) begin bad++; $display("FAIL noop got=%b exp=1000", {done, bus_err, misalign, dmem_req}); end
    step();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bit seen_done = 1'b0;
    do_start(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    if (dmem_req) req_cycles++;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      step();
      if (dmem_req) req_cycles++;
      if (done) begin
        seen_done = 1'b1;
        total++; if (bus_err !== 1'b1 || load_data !== 64'h0) begin bad++; $display("FAIL to_err got=%b/%h exp=1/0", bus_err, load_data); end
      end
    end
    total++; if (!seen_done) begin bad++; $display("FAIL to_done got=0 exp=1"); end
    total++; if (req_cycles != 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", req_cycles); end
    step();
    dmem_ack = 1'b1; dmem_rdata = 64'h5555; step(); dmem_ack = 1'b0;
    step();
    total++; if ({done, busy, dmem_req, bus_err} !== 4'b0001 || load_data !== 64'h0) begin bad++; $display("FAIL late_ack got=%b/%h exp=0001/0", {done, busy, dmem_req, bus_err}, load_data); end
  endtask

  task automatic test_reset_mid_and_busy();
    do_start(1'b1, 1'b0, 3'b011, 64'h8, 64'h0);
    step();
    rst_n = 1'b0;
    #1;
    total++; if ({dmem_req, busy, done} !== 3'b000) begin bad++; $display("FAIL mid_rst got=%b exp=000", {dmem_req, busy, done}); end
    step();
    rst_n = 1'b1;
    step();
    do_start(1'b1, 1'b0, 3'b011, 64'h8, 64'h0);
    do_start(1'b0, 1'b1, 3'b011, 64'h40, 64'hFFFF);
    total++; if ({dmem_req, dmem_we} !== 2'b10 || dmem_addr !== 64'h8) begin bad++; $display("FAIL busy_start got=%b/%h exp=10/8", {dmem_req, dmem_we}, dmem_addr); end
    dmem_rdata = 64'hDEADBEEF01234567; dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    total++; if (done !== 1'b1 || load_data !== 64'hDEADBEEF01234567) begin bad++; $display("FAIL ld8_data got=%b/%h exp=1/deadbeef01234567", done, load_data); end
    step(); step();
    total++; if ({dmem_req, busy, done} !== 3'b000) begin bad++; $display("FAIL no_second got=%b exp=000", {dmem_req, busy, done}); end
  endtask

  initial begin
    test_reset();
    test_sd();
    test_sb_sh();
    test_loads();
    test_errors();
    test_timeout();
    test_reset_mid_and_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
